// File: rtl/msfsm_pkg.sv
// Shared types and constants for the MSFSM gate controllers.
package msfsm_pkg;

  typedef enum logic [1:0] {
    IDLE_LO   = 2'd0,
    RISE_PEND = 2'd1,
    IDLE_HI   = 2'd2,
    FALL_PEND = 2'd3
  } state_t;

  localparam int FUNC_XOR  = 0;
  localparam int FUNC_AND  = 1;
  localparam int FUNC_OR   = 2;
  localparam int FUNC_C    = 3;

  localparam int ERR_CNT_W = 8;

  // Output level a state is committed to, or heading towards.
  function automatic logic state_level(input state_t s);
    return (s == IDLE_HI) || (s == RISE_PEND);
  endfunction

endpackage

// File: rtl/msfsm_in_tracker.sv
// Per-input level tracking for dual-rail rise/fall events.
// Invalid events are dropped and reported through ev_err.
module msfsm_in_tracker #(
  parameter int              N_IN    = 2,
  parameter logic [N_IN-1:0] IN_INIT = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] in_P,
  input  logic [N_IN-1:0] in_M,
  output logic [N_IN-1:0] lvl,
  output logic [N_IN-1:0] nxt_lvl,
  output logic            ev_err
);

  logic [N_IN-1:0] rise;
  logic [N_IN-1:0] fall;
  logic [N_IN-1:0] bad;

  always_comb begin
    rise    = in_P & ~in_M & ~lvl;
    fall    = in_M & ~in_P &  lvl;
    nxt_lvl = (lvl | rise) & ~fall;
    // Simultaneous rise+fall, or an event that repeats the current level.
    bad     = (in_P & in_M) | (in_P & lvl) | (in_M & ~lvl);
    ev_err  = |bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lvl <= IN_INIT;
    else       lvl <= nxt_lvl;
  end

endmodule

// File: rtl/msfsm_gate_mealy.sv
// N-input gate MSFSM controller with Mealy output events and ack handshake.
// Define MSFSM_ERR_CNT_EN to add the saturating err_cnt output.
module msfsm_gate_mealy
  import msfsm_pkg::*;
#(
  parameter int              N_IN     = 2,
  parameter int              FUNC     = FUNC_XOR,
  parameter logic [N_IN-1:0] IN_INIT  = '0,
  parameter logic            OUT_INIT = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] in_P,
  input  logic [N_IN-1:0] in_M,
  input  logic            out_ack,
  output logic            out_P,
  output logic            out_M,
  output logic            out_lvl,
  output logic [N_IN-1:0] in_lvl,
  output logic            busy,
  output logic            err_proto,
  output logic            err_hazard
`ifdef MSFSM_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  state_t          state;
  logic [N_IN-1:0] nxt_lvl;
  logic            ev_err;
  logic            tgt;
  logic            ack_err;
  logic            hazard_now;
  logic            proto_now;

  msfsm_in_tracker #(
    .N_IN    (N_IN),
    .IN_INIT (IN_INIT)
  ) u_tracker (
    .clk     (clk),
    .reset   (reset),
    .in_P    (in_P),
    .in_M    (in_M),
    .lvl     (in_lvl),
    .nxt_lvl (nxt_lvl),
    .ev_err  (ev_err)
  );

  always_comb begin
    tgt = 1'b0;
    case (FUNC)
      FUNC_XOR: tgt = ^nxt_lvl;
      FUNC_AND: tgt = &nxt_lvl;
      FUNC_OR:  tgt = |nxt_lvl;
      default: begin
        // C-element holds the current state's level on mixed inputs.
        if (&nxt_lvl)       tgt = 1'b1;
        else if (~|nxt_lvl) tgt = 1'b0;
        else                tgt = state_level(state);
      end
    endcase
  end

  always_comb begin
    ack_err    = out_ack && (((state == IDLE_LO) && !tgt) || ((state == IDLE_HI) && tgt));
    hazard_now = ((state == RISE_PEND) && !tgt) || ((state == FALL_PEND) && tgt);
    proto_now  = ev_err || ack_err;
  end

  // Mealy requests, forced low while reset is held.
  assign out_P = !reset && (((state == IDLE_LO) && tgt) || (state == RISE_PEND));
  assign out_M = !reset && (((state == IDLE_HI) && !tgt) || (state == FALL_PEND));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= OUT_INIT ? IDLE_HI : IDLE_LO;
      out_lvl    <= OUT_INIT;
      busy       <= 1'b0;
      err_proto  <= 1'b0;
      err_hazard <= 1'b0;
`ifdef MSFSM_ERR_CNT_EN
      err_cnt    <= '0;
`endif
    end else begin
      err_proto  <= err_proto  | proto_now;
      err_hazard <= err_hazard | hazard_now;
`ifdef MSFSM_ERR_CNT_EN
      if ((proto_now || hazard_now) && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
`endif
      case (state)
        IDLE_LO: if (tgt) begin
          if (out_ack) begin
            state   <= IDLE_HI;
            out_lvl <= 1'b1;
          end else begin
            state   <= RISE_PEND;
            busy    <= 1'b1;
          end
        end
        RISE_PEND: if (out_ack) begin
          state   <= IDLE_HI;
          out_lvl <= 1'b1;
          busy    <= 1'b0;
        end
        IDLE_HI: if (!tgt) begin
          if (out_ack) begin
            state   <= IDLE_LO;
            out_lvl <= 1'b0;
          end else begin
            state   <= FALL_PEND;
            busy    <= 1'b1;
          end
        end
        FALL_PEND: if (out_ack) begin
          state   <= IDLE_LO;
          out_lvl <= 1'b0;
          busy    <= 1'b0;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: doc/msfsm_gate_mealy.md
Name: msfsm_gate_mealy

Overview:
- Parametrised synchronous Mealy controller for an N-input gate with dual-rail event interface: `_P` means rising transition, `_M` means falling transition.
- It generalises the fixed two-input XOR MSFSM composition to N_IN inputs and a selectable gate function.
- It adds an output acknowledge handshake, hazard detection and protocol-error detection.
- It sits between the environment event sources and the output event consumers in the synchronous MSFSM flow.

Parameters:
- N_IN, 2, number of gate inputs (2..8).
- FUNC, 0, gate function: 0 XOR, 1 AND, 2 OR, 3 C-element.
- IN_INIT, 0, N_IN-bit reset level of the input-level register.
- OUT_INIT, 0, reset level of the output.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- in_P  in  N_IN  per-input rise event, single-cycle pulse.
- in_M  in  N_IN  per-input fall event, single-cycle pulse.
- out_ack  in  1  environment consumed the pending output event.
- out_P  out  1  output rise event request (Mealy).
- out_M  out  1  output fall event request (Mealy).
- out_lvl  out  1  committed output level.
- in_lvl  out  N_IN  tracked input levels.
- busy  out  1  output event pending.
- err_proto  out  1  sticky protocol error.
- err_hazard  out  1  sticky hazard flag.
- err_cnt  out  8  saturating error count (only with MSFSM_ERR_CNT_EN).

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values:
  - in_lvl = IN_INIT.
  - State = IDLE_LO if OUT_INIT = 0, otherwise IDLE_HI.
  - out_lvl = OUT_INIT.
  - busy = 0; err_proto = 0; err_hazard = 0; err_cnt = 0.
  - out_P and out_M are 0 while reset is asserted.
- Input tracking:
  - A valid event is in_P[i] with in_lvl[i] = 0, or in_M[i] with in_lvl[i] = 1.
  - nxt_lvl is in_lvl with the valid events applied. in_lvl <= nxt_lvl on each edge.
  - Invalid events are ignored and set err_proto: a redundant event, or in_P[i] and in_M[i] together.
- Target function tgt, computed from nxt_lvl:
  - XOR: reduction XOR.
  - AND: all ones.
  - OR: any one.
  - C-element: 1 if all ones, 0 if all zeros, otherwise the current state's target level (IDLE_LO/FALL_PEND → 0, IDLE_HI/RISE_PEND → 1).
- State machine, with Mealy outputs:
  - IDLE_LO:
    - tgt = 1: out_P = 1 in the same cycle. Next state is RISE_PEND, or IDLE_HI if out_ack is high in that same cycle.
    - out_ack while no request: err_proto, ack ignored.
  - RISE_PEND:
    - out_P = 1, busy = 1.
    - out_ack → IDLE_HI, out_lvl <= 1.
    - tgt = 0 while pending: err_hazard is set. The request is not withdrawn and out_P stays high until acked.
  - IDLE_HI and FALL_PEND: symmetric, using out_M.
  - After an ack, if tgt already disagrees with the new level, the opposite event is requested in the next cycle (Mealy, from IDLE).
- out_P and out_M are never high together. out_lvl changes only on ack.
- Error flags are sticky until reset.
- Reset asserted mid-pending: the request is dropped immediately and all state returns to reset values.
- If IN_INIT and OUT_INIT are inconsistent with FUNC, an event is requested in the first cycle after reset. This is legal.

Optional Feature:
- Macro: MSFSM_ERR_CNT_EN.
- Defined:
  - err_cnt is an 8-bit counter, +1 per cycle in which any protocol or hazard condition occurs.
  - It saturates at 255 and resets to 0.
- Undefined: port err_cnt absent. Sticky flags only.

Decomposition:
- Shared package msfsm_pkg:
  - State enum: IDLE_LO, RISE_PEND, IDLE_HI, FALL_PEND.
  - FUNC encodings: FUNC_XOR, FUNC_AND, FUNC_OR, FUNC_C.
  - ERR_CNT_W = 8.
- Sub-module msfsm_in_tracker: per-input level register, event validation and nxt_lvl generation.
- The function/target logic and the FSM stay in the top module.

Test Plan:
- XOR, N_IN = 2, reset levels 0/0:
  - in_P = 01 → out_P = 1 in the same cycle, busy = 1 next cycle.
  - out_ack two cycles later → out_lvl = 1, busy = 0.
- AND, N_IN = 3:
  - Raise inputs one per cycle; out_P asserts only in the cycle of the third rise.
  - An out_ack in the same cycle gives out_lvl = 1 next cycle and busy never set.
- C-element, N_IN = 2, levels 11, out_lvl = 1:
  - in_M = 01 → no event.
  - in_M = 10 → out_M = 1, then ack → out_lvl = 0.
- Hazard, XOR:
  - in_P[0] → RISE_PEND; next cycle in_P[1] → err_hazard = 1, out_P still 1.
  - Ack → IDLE_HI; next cycle out_M = 1.
- Protocol:
  - in_P[0] with in_lvl[0] = 1 → err_proto = 1, in_lvl unchanged.
  - out_ack in IDLE → err_proto stays 1.
  - With MSFSM_ERR_CNT_EN: err_cnt = 2; 300 error cycles → 255.
- Reset mid-RISE_PEND:
  - out_P drops asynchronously.
  - After release: in_lvl = IN_INIT, out_lvl = OUT_INIT, flags 0.
